// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction sequencer: operation selects,
// opcode nibbles and FSM states.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_LDI = 3'd1,
      OP_INC = 3'd2,
      OP_ST  = 3'd3,
      OP_ADD = 3'd4,
      OP_LD  = 3'd5,
      OP_RST = 3'd6,
      OP_ILL = 3'd7
   } op_e;

   localparam logic [3:0] NIB_ADD = 4'h5;
   localparam logic [3:0] NIB_INC = 4'h9;
   localparam logic [3:0] NIB_LD  = 4'hA;
   localparam logic [3:0] NIB_ST  = 4'hB;
   localparam logic [3:0] NIB_NOP = 4'hC;
   localparam logic [3:0] NIB_LDI = 4'hD;
   localparam logic [3:0] NIB_RST = 4'hE;

   localparam logic [7:0] IR_RESET = 8'hC0;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_e;

endpackage

// File: rtl/op_decoder.sv
// Combinational mapping from the opcode nibble to the datapath operation select.
module op_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] nib_i,
   output op_e        op_o
);

   always_comb begin
      op_o = OP_ILL;
      case (nib_i)
         NIB_ADD: op_o = OP_ADD;
         NIB_INC: op_o = OP_INC;
         NIB_LD:  op_o = OP_LD;
         NIB_ST:  op_o = OP_ST;
         NIB_NOP: op_o = OP_NOP;
         NIB_LDI: op_o = OP_LDI;
         NIB_RST: op_o = OP_RST;
         default: op_o = OP_ILL;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Three-phase FETCH/DECODE/EXECUTE instruction sequencer with sticky illegal flag.
// Define ILLEGAL_TRAP_EN to park the FSM in HALT on an undefined opcode.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  EN,
   output logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [WIDTH-1:0]      DATA,
   output logic [2:0]            OP_SEL,
   output logic [3:0]            IMM,
   output logic                  EXEC_STB,
   output logic                  ILLEGAL
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0]      ir_q, ir_d;
   op_e                   op_q, op_d;
   logic [3:0]            imm_q, imm_d;
   logic                  ill_q, ill_d;
   logic                  exec_stb;
   op_e                   dec_op;

   op_decoder u_op_decoder (
      .nib_i (ir_q[7:4]),
      .op_o  (dec_op)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= WIDTH'(IR_RESET);
         op_q    <= OP_NOP;
         imm_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         ill_q   <= ill_d;
      end
   end

   // Everything holds unless EN is high; the strobe is gated by EN so a stalled
   // EXECUTE never reports a second execution.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      op_d     = op_q;
      imm_d    = imm_q;
      ill_d    = ill_q;
      exec_stb = 1'b0;
      if (EN) begin
         case (state_q)
            S_FETCH: begin
               ir_d    = DATA;
               pc_d    = pc_q + ADDR_WIDTH'(1);
               state_d = S_DECODE;
            end
            S_DECODE: begin
               op_d    = dec_op;
               imm_d   = ir_q[3:0];
               state_d = S_EXECUTE;
               if (dec_op == OP_ILL) begin
                  ill_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_HALT;
`endif
               end
            end
            S_EXECUTE: begin
               exec_stb = 1'b1;
               state_d  = S_FETCH;
               if (op_q == OP_RST) pc_d = '0;
            end
            default: state_d = state_q;
         endcase
      end
   end

   assign ADDR     = pc_q;
   assign OP_SEL   = op_q;
   assign IMM      = imm_q;
   assign EXEC_STB = exec_stb;
   assign ILLEGAL  = ill_q;

endmodule
